// File: rtl/enqueue_agent.sv
// Enqueue agent: per-beat port selection for the buffer bank and PIFO calendars.
// Latency: enables are registered, one cycle after the accepted beat.
// Backpressure: none; tready is held high after reset, and full ports drop the packet.
module enqueue_agent #(
  parameter int PORT_NUM    = 5,
  parameter int TUSER_WIDTH = 128,
  parameter int DST_LSB     = 24
) (
  input  logic                   axis_aclk,
  input  logic                   axis_resetn,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tlast_f1,
  input  logic                   s_axis_tpifo_valid,
  input  logic [PORT_NUM-1:0]    s_axis_buffer_almost_full,
  input  logic [PORT_NUM-1:0]    s_axis_pifo_full,
  output logic                   m_axis_valid,
  output logic [PORT_NUM-1:0]    m_axis_ctl_pifo_in_en,
  output logic [PORT_NUM-1:0]    m_axis_ctl_buffer_wr_en
);

  // Only the destination field of tuser matters here; the rest is folded into
  // a sink so the unused metadata bits stay visibly intentional.
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  logic                beat_acc;
  logic [PORT_NUM-1:0] dst;
  logic [PORT_NUM-1:0] fresh_mask;
  logic [PORT_NUM-1:0] held_mask;
  logic [PORT_NUM-1:0] beat_mask;
  logic                pifo_insert;

  assign beat_acc = s_axis_tvalid & s_axis_tready;
  assign dst      = s_axis_tuser[DST_LSB +: PORT_NUM];

  // Port mask for the current beat: the first beat samples the full flags,
  // later beats reuse the mask captured then so a packet is never truncated.
  always_comb begin
    fresh_mask  = dst & ~s_axis_buffer_almost_full
                      & ~({PORT_NUM{s_axis_tpifo_valid}} & s_axis_pifo_full);
    beat_mask   = s_axis_tlast_f1 ? fresh_mask : held_mask;
    pifo_insert = beat_acc & s_axis_tlast_f1 & s_axis_tpifo_valid;
  end

  // Ready comes up on the first edge after reset release and never drops.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) s_axis_tready <= 1'b0;
    else              s_axis_tready <= 1'b1;
  end

  // Hold the packet's mask across its beats; the last beat clears it so a
  // stray continuation beat (e.g. after reset mid-packet) writes nowhere.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      held_mask <= '0;
    end else if (beat_acc) begin
      held_mask <= s_axis_tlast ? '0 : beat_mask;
    end
  end

  // Registered enables: one pulse per accepted beat, PIFO insert only on the
  // first beat of a packet that carries rank metadata.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      m_axis_valid            <= 1'b0;
      m_axis_ctl_buffer_wr_en <= '0;
      m_axis_ctl_pifo_in_en   <= '0;
    end else begin
      m_axis_valid            <= beat_acc;
      m_axis_ctl_buffer_wr_en <= beat_acc ? beat_mask : '0;
      m_axis_ctl_pifo_in_en   <= pifo_insert ? fresh_mask : '0;
    end
  end

endmodule

// File: tb/tb_enqueue_agent.sv
// Bench for enqueue_agent: directed vector table, reset corner sequences,
// then randomized packet traffic against a packet-level reference model.
module tb_enqueue_agent;

  logic         axis_aclk = 1'b0;
  logic         axis_resetn;
  logic         s_axis_tready;
  logic         s_axis_tvalid;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tlast;
  logic         s_axis_tlast_f1;
  logic         s_axis_tpifo_valid;
  logic [4:0]   s_axis_buffer_almost_full;
  logic [4:0]   s_axis_pifo_full;
  logic         m_axis_valid;
  logic [4:0]   m_axis_ctl_pifo_in_en;
  logic [4:0]   m_axis_ctl_buffer_wr_en;

  int checks   = 0;
  int failures = 0;

  always #5 axis_aclk = ~axis_aclk;

  enqueue_agent dut (
    .axis_aclk                 (axis_aclk),
    .axis_resetn               (axis_resetn),
    .s_axis_tready             (s_axis_tready),
    .s_axis_tvalid             (s_axis_tvalid),
    .s_axis_tuser              (s_axis_tuser),
    .s_axis_tlast              (s_axis_tlast),
    .s_axis_tlast_f1           (s_axis_tlast_f1),
    .s_axis_tpifo_valid        (s_axis_tpifo_valid),
    .s_axis_buffer_almost_full (s_axis_buffer_almost_full),
    .s_axis_pifo_full          (s_axis_pifo_full),
    .m_axis_valid              (m_axis_valid),
    .m_axis_ctl_pifo_in_en     (m_axis_ctl_pifo_in_en),
    .m_axis_ctl_buffer_wr_en   (m_axis_ctl_buffer_wr_en)
  );

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] dst;
    logic       f1;
    logic       last;
    logic       pv;
    logic [4:0] af;
    logic [4:0] pf;
    logic       ev;
    logic [4:0] ep;
    logic [4:0] ew;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; non-destination tuser bits are random.
  task automatic drive(input logic v, input logic [4:0] dst, input logic f1,
                       input logic last, input logic pv,
                       input logic [4:0] af, input logic [4:0] pf);
    s_axis_tvalid             = v;
    s_axis_tuser              = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tuser[28:24]       = dst;
    s_axis_tlast_f1           = f1;
    s_axis_tlast              = last;
    s_axis_tpifo_valid        = pv;
    s_axis_buffer_almost_full = af;
    s_axis_pifo_full          = pf;
  endtask

  task automatic step_chk(input string tag, input logic ev,
                          input logic [4:0] ep, input logic [4:0] ew);
    @(posedge axis_aclk);
    #1;
    chk({tag, ".valid"}, {7'd0, m_axis_valid}, {7'd0, ev});
    chk({tag, ".pifo"},  {3'd0, m_axis_ctl_pifo_in_en}, {3'd0, ep});
    chk({tag, ".wr"},    {3'd0, m_axis_ctl_buffer_wr_en}, {3'd0, ew});
  endtask

  // Reference model state: mask of the packet currently in flight.
  logic [4:0] pkt_mask;
  logic       in_pkt;

  initial begin
    // Directed vectors, applied back to back after reset release.
    tbl[0]  = '{"single",     1, 5'b00100, 1, 1, 1, 5'b00000, 5'b00000, 1, 5'b00100, 5'b00100};
    tbl[1]  = '{"mc_b1",      1, 5'b10011, 1, 0, 1, 5'b00000, 5'b00000, 1, 5'b10011, 5'b10011};
    tbl[2]  = '{"mc_b2",      1, 5'b00000, 0, 0, 1, 5'b00000, 5'b00000, 1, 5'b00000, 5'b10011};
    tbl[3]  = '{"mc_b3",      1, 5'b00000, 0, 1, 1, 5'b00000, 5'b00000, 1, 5'b00000, 5'b10011};
    tbl[4]  = '{"idle",       0, 5'b11111, 1, 1, 1, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000};
    tbl[5]  = '{"af_b1",      1, 5'b00011, 1, 0, 1, 5'b00001, 5'b00000, 1, 5'b00010, 5'b00010};
    tbl[6]  = '{"af_b2",      1, 5'b00000, 0, 0, 1, 5'b00011, 5'b00000, 1, 5'b00000, 5'b00010};
    tbl[7]  = '{"af_b3",      1, 5'b00000, 0, 1, 1, 5'b00011, 5'b11111, 1, 5'b00000, 5'b00010};
    tbl[8]  = '{"pf_pv1",     1, 5'b01000, 1, 1, 1, 5'b00000, 5'b01000, 1, 5'b00000, 5'b00000};
    tbl[9]  = '{"pf_pv0",     1, 5'b01000, 1, 1, 0, 5'b00000, 5'b01000, 1, 5'b00000, 5'b01000};
    tbl[10] = '{"dst_zero",   1, 5'b00000, 1, 1, 1, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000};
    tbl[11] = '{"all_masked", 1, 5'b11111, 1, 1, 1, 5'b10101, 5'b01010, 1, 5'b00000, 5'b00000};
    tbl[12] = '{"gap_b1",     1, 5'b00101, 1, 0, 0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00101};
    tbl[13] = '{"gap_idle",   0, 5'b11111, 1, 1, 1, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000};
    tbl[14] = '{"gap_b2",     1, 5'b00000, 0, 1, 0, 5'b11111, 5'b00000, 1, 5'b00000, 5'b00101};
    tbl[15] = '{"after_last", 1, 5'b11111, 0, 1, 1, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000};

    // Reset held for two cycles.
    axis_resetn = 1'b0;
    drive(1, 5'b11111, 1, 1, 1, 5'b00000, 5'b00000);
    repeat (2) @(posedge axis_aclk);
    #1;
    chk("rst.tready", {7'd0, s_axis_tready}, 8'd0);
    chk("rst.valid",  {7'd0, m_axis_valid}, 8'd0);
    chk("rst.pifo",   {3'd0, m_axis_ctl_pifo_in_en}, 8'd0);
    chk("rst.wr",     {3'd0, m_axis_ctl_buffer_wr_en}, 8'd0);
    axis_resetn = 1'b1;
    drive(0, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000);
    #1;
    chk("rel.tready_before_edge", {7'd0, s_axis_tready}, 8'd0);
    @(posedge axis_aclk);
    #1;
    chk("rel.tready", {7'd0, s_axis_tready}, 8'd1);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].dst, tbl[i].f1, tbl[i].last, tbl[i].pv, tbl[i].af, tbl[i].pf);
      step_chk(tbl[i].name, tbl[i].ev, tbl[i].ep, tbl[i].ew);
    end

    // Reset in the middle of a 4-beat packet.
    drive(1, 5'b00110, 1, 0, 1, 5'b00000, 5'b00000);
    step_chk("mid_b1", 1, 5'b00110, 5'b00110);
    drive(1, 5'b00000, 0, 0, 1, 5'b00000, 5'b00000);
    axis_resetn = 1'b0;
    #1;
    chk("mid_rst.async_valid", {7'd0, m_axis_valid}, 8'd0);
    chk("mid_rst.async_wr",    {3'd0, m_axis_ctl_buffer_wr_en}, 8'd0);
    chk("mid_rst.tready",      {7'd0, s_axis_tready}, 8'd0);
    @(posedge axis_aclk);
    #1;
    axis_resetn = 1'b1;
    drive(0, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000);
    step_chk("mid_rel", 0, 5'b00000, 5'b00000);
    chk("mid_rel.tready", {7'd0, s_axis_tready}, 8'd1);
    drive(1, 5'b11111, 0, 0, 1, 5'b00000, 5'b00000);
    step_chk("mid_b3", 1, 5'b00000, 5'b00000);
    drive(1, 5'b11111, 0, 1, 1, 5'b00000, 5'b00000);
    step_chk("mid_b4", 1, 5'b00000, 5'b00000);
    drive(1, 5'b00001, 1, 1, 1, 5'b00000, 5'b00000);
    step_chk("mid_next", 1, 5'b00001, 5'b00001);

    // Randomized packet traffic with idle gaps and changing full flags.
    pkt_mask = '0;
    in_pkt   = 1'b0;
    for (int p = 0; p < 300; p++) begin
      int         len;
      logic [4:0] dst;
      logic       pv;
      len = $urandom_range(1, 4);
      dst = 5'($urandom);
      pv  = 1'($urandom);
      for (int b = 0; b < len; b++) begin
        logic [4:0] af, pf, ep, ew;
        logic       first, last;
        while ($urandom_range(0, 3) == 0) begin
          drive(0, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom), 5'($urandom));
          step_chk("rnd_idle", 0, 5'b00000, 5'b00000);
        end
        first = (b == 0);
        last  = (b == len - 1);
        af    = 5'($urandom) & 5'($urandom);
        pf    = 5'($urandom) & 5'($urandom);
        // Later beats carry junk in the destination field; only the first counts.
        drive(1, first ? dst : 5'($urandom), first, last, pv, af, pf);
        if (first) begin
          pkt_mask = '0;
          for (int k = 0; k < 5; k++) begin
            if (dst[k] && !af[k] && !(pv && pf[k])) pkt_mask[k] = 1'b1;
          end
          in_pkt = 1'b1;
        end
        ew = in_pkt ? pkt_mask : 5'b00000;
        ep = (first && pv) ? pkt_mask : 5'b00000;
        step_chk("rnd_beat", 1, ep, ew);
        if (last) in_pkt = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
